// File: rtl/vga_mem_arbiter_if.sv
// Host-side request/acknowledge bus for the video RAM arbiter.
// The master raises req with stable fields and holds them until ack.
interface vga_mem_arbiter_if #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 8
);
  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              ack;
  logic [DATA_W-1:0] rdata;

  modport master (
    output req,
    output we,
    output addr,
    output wdata,
    input  ack,
    input  rdata
  );

  modport slave (
    input  req,
    input  we,
    input  addr,
    input  wdata,
    output ack,
    output rdata
  );
endinterface

// File: rtl/vga_mem_arbiter.sv
// Single-port video RAM arbiter: display fetch always wins,
// host accesses fill idle cycles with fixed pipelined latency.
module vga_mem_arbiter #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              disp_req_i,
  input  logic [ADDR_W-1:0] disp_addr_i,
  output logic [DATA_W-1:0] disp_data_o,
  output logic              disp_valid_o,
  vga_mem_arbiter_if.slave  host,
  output logic              ram_en_o,
  output logic              ram_we_o,
  output logic [ADDR_W-1:0] ram_addr_o,
  output logic [DATA_W-1:0] ram_wdata_o,
  input  logic [DATA_W-1:0] ram_rdata_i,
  output logic [15:0]       conflict_cnt_o
);

  typedef enum logic [1:0] {
    IDLE,
    WR_ACK,
    RD_WAIT,
    RD_ACK
  } state_e;

  state_e            state_q;
  logic              tag_vld_q;
  logic              tag_host_q;
  logic              disp_valid_q;
  logic [DATA_W-1:0] disp_data_q;
  logic              ack_q;
  logic [DATA_W-1:0] rdata_q;
  logic [15:0]       cnt_q;

  logic disp_iss;
  logic host_iss;
  logic host_rd_iss;
  logic blocked;

  assign disp_iss    = disp_req_i & ~rst_i;
  assign host_iss    = host.req & ~disp_req_i &
                       (state_q == IDLE) & ~rst_i;
  assign host_rd_iss = host_iss & ~host.we;
  assign blocked     = host.req & disp_req_i &
                       (state_q == IDLE);

  // Port drive follows the current-cycle grant directly.
  always_comb begin
    ram_en_o    = 1'b0;
    ram_we_o    = 1'b0;
    ram_addr_o  = '0;
    ram_wdata_o = '0;
    if (disp_iss) begin
      ram_en_o   = 1'b1;
      ram_addr_o = disp_addr_i;
    end else if (host_iss) begin
      ram_en_o   = 1'b1;
      ram_we_o   = host.we;
      ram_addr_o = host.addr;
      if (host.we) begin
        ram_wdata_o = host.wdata;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      tag_vld_q    <= 1'b0;
      tag_host_q   <= 1'b0;
      disp_valid_q <= 1'b0;
      disp_data_q  <= '0;
      ack_q        <= 1'b0;
      rdata_q      <= '0;
      cnt_q        <= '0;
    end else begin
      // Owner tag rides alongside the one-cycle RAM read latency.
      tag_vld_q    <= disp_iss | host_rd_iss;
      tag_host_q   <= host_rd_iss;
      disp_valid_q <= tag_vld_q & ~tag_host_q;
      if (tag_vld_q && !tag_host_q) begin
        disp_data_q <= ram_rdata_i;
      end
      if (blocked && cnt_q != 16'hFFFF) begin
        cnt_q <= cnt_q + 16'd1;
      end
      ack_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (host_iss) begin
            if (host.we) begin
              state_q <= WR_ACK;
              ack_q   <= 1'b1;
            end else begin
              state_q <= RD_WAIT;
            end
          end
        end
        RD_WAIT: begin
          if (tag_vld_q && tag_host_q) begin
            rdata_q <= ram_rdata_i;
          end
          ack_q   <= 1'b1;
          state_q <= RD_ACK;
        end
        WR_ACK:  state_q <= IDLE;
        RD_ACK:  state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign disp_data_o    = disp_data_q;
  assign disp_valid_o   = disp_valid_q;
  assign host.ack       = ack_q;
  assign host.rdata     = rdata_q;
  assign conflict_cnt_o = cnt_q;

endmodule
